onehot_strobe_decoder: RTL and testbench

- Inverse of the team's 4-to-2 priority encoder: takes an encoded index plus valid and drives the matching one-hot enable line.
- Each accepted index produces a one-hot strobe that is registered and held for a fixed number of cycles.
- Sits downstream of an encoder or arbiter and drives enable lines that need a minimum pulse width.
- Uses a valid/ready handshake, so upstream logic stalls while a strobe is in progress.

---
 rtl/onehot_strobe_decoder.sv | 69 ++++++
 tb/tb_onehot_strobe_decoder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/onehot_strobe_decoder.sv
// Binary index to one-hot strobe decoder.
// Each accepted index drives a registered one-hot line for HOLD cycles.
module onehot_strobe_decoder #(
    parameter int IDX_W = 2,
    parameter int HOLD  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IDX_W-1:0]      in_code,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  abort,
    output logic [(2**IDX_W)-1:0] out_onehot,
    output logic                  out_valid,
    output logic                  done
);

    localparam int N = 2 ** IDX_W;
    localparam logic [N-1:0] ONE = N'(1);
    localparam logic [7:0] RELOAD = 8'(HOLD - 1);

    if (HOLD < 1 || HOLD > 255) begin : g_hold_check
        $error("HOLD must be in 1..255");
    end

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       last;
    logic       accept;

    assign last     = (state == S_HOLD) && (cnt == 8'd0);
    assign in_ready = (state == S_IDLE) || (cnt == 8'd0);
    assign done     = last && !abort;
    assign accept   = in_valid && in_ready && !abort;

    // Abort outranks accept; a reload in the last cycle leaves no gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            out_onehot <= '0;
            out_valid  <= 1'b0;
        end else if (abort) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            out_onehot <= '0;
            out_valid  <= 1'b0;
        end else if (accept) begin
            state      <= S_HOLD;
            cnt        <= RELOAD;
            out_onehot <= ONE << in_code;
            out_valid  <= 1'b1;
        end else if (state == S_HOLD) begin
            if (cnt == 8'd0) begin
                state      <= S_IDLE;
                out_onehot <= '0;
                out_valid  <= 1'b0;
            end else begin
                cnt <= cnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// Bench for onehot_strobe_decoder: HOLD=4 and HOLD=1 instances share
// stimulus; a queue-based model predicts every strobe cycle.
module tb_onehot_strobe_decoder;

    typedef struct packed {
        logic [3:0] oh;
        logic       last;
    } item_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] in_code;
    logic       in_valid;
    logic       abort;
    logic       rdy [2];
    logic [3:0] oh  [2];
    logic       ov  [2];
    logic       dn  [2];

    int    errors = 0;
    int    checks = 0;
    item_t q [2][$];
    int    holds [2] = '{4, 1};

    onehot_strobe_decoder #(.IDX_W(2), .HOLD(4)) d4 (
        .clk(clk), .rst_n(rst_n), .in_code(in_code),
        .in_valid(in_valid), .in_ready(rdy[0]), .abort(abort),
        .out_onehot(oh[0]), .out_valid(ov[0]), .done(dn[0])
    );

    onehot_strobe_decoder #(.IDX_W(2), .HOLD(1)) d1 (
        .clk(clk), .rst_n(rst_n), .in_code(in_code),
        .in_valid(in_valid), .in_ready(rdy[1]), .abort(abort),
        .out_onehot(oh[1]), .out_valid(ov[1]), .done(dn[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each negedge compares the DUT against the next predicted cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (q[i].size() > 0 || ov[i]) begin
                if (q[i].size() == 0) begin
                    chk($sformatf("unexpected_strobe%0d", i),
                        {2'b0, ov[i], dn[i], oh[i]}, 8'h00);
                end else begin
                    item_t it;
                    it = q[i].pop_front();
                    chk($sformatf("strobe%0d", i),
                        {2'b0, ov[i], dn[i], oh[i]},
                        {2'b0, 1'b1, it.last && !abort, it.oh});
                end
            end else begin
                chk($sformatf("idle%0d", i),
                    {2'b0, ov[i], dn[i], oh[i]}, 8'h00);
            end
        end
    end

    // Called at posedge+1; drives one cycle and updates the model at the edge.
    task automatic step(input logic v, input logic [1:0] c, input logic a);
        logic acc [2];
        in_valid = v;
        in_code  = c;
        abort    = a;
        for (int i = 0; i < 2; i++) begin
            logic er;
            er = (q[i].size() <= 1);
            chk($sformatf("ready%0d", i), {7'b0, rdy[i]}, {7'b0, er});
            acc[i] = v && er && !a;
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (a) q[i].delete();
            if (acc[i]) begin
                for (int j = 0; j < holds[i]; j++)
                    q[i].push_back(item_t'{oh: 4'b0001 << c,
                                           last: (j == holds[i] - 1)});
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 2'd0, 1'b0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        abort    = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_out%0d", i),
                {2'b0, ov[i], dn[i], oh[i]}, 8'h00);
            q[i].delete();
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 2; i++)
            chk($sformatf("rst_ready%0d", i), {7'b0, rdy[i]}, 8'h01);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_code  = 2'd0;
        in_valid = 1'b0;
        abort    = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        do_reset();

        // single strobe
        step(1'b1, 2'd2, 1'b0);
        chk("single_oh", {4'b0, oh[0]}, 8'h04);
        idle(5);

        // back-to-back: code 0 offered in code 3's last hold cycle
        step(1'b1, 2'd3, 1'b0);
        idle(3);
        step(1'b1, 2'd0, 1'b0);
        chk("b2b_oh", {4'b0, oh[0]}, 8'h01);
        idle(5);

        // backpressure: code changes while busy
        step(1'b1, 2'd2, 1'b0);
        step(1'b1, 2'd1, 1'b0);
        step(1'b1, 2'd1, 1'b0);
        step(1'b1, 2'd3, 1'b0);
        step(1'b1, 2'd3, 1'b0);
        chk("bp_oh", {4'b0, oh[0]}, 8'h08);
        idle(5);

        // abort in 2nd hold cycle, then abort with valid in idle
        step(1'b1, 2'd1, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        step(1'b0, 2'd0, 1'b1);
        chk("abort_oh", {4'b0, oh[0]}, 8'h00);
        chk("abort_ready", {7'b0, rdy[0]}, 8'h01);
        step(1'b1, 2'd2, 1'b1);
        chk("abort_idle_oh", {4'b0, oh[0]}, 8'h00);
        idle(2);

        // consecutive codes (HOLD=1 instance takes one per cycle)
        for (int k = 0; k < 4; k++) step(1'b1, 2'(k), 1'b0);
        chk("h1_last_oh", {4'b0, oh[1]}, 8'h08);
        idle(5);

        // async reset mid-strobe, then a normal accept
        step(1'b1, 2'd3, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        do_reset();
        step(1'b1, 2'd1, 1'b0);
        chk("post_rst_oh", {4'b0, oh[0]}, 8'h02);
        idle(5);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 3) != 0),
                     2'($urandom_range(0, 3)),
                     ($urandom_range(0, 9) == 0));
            end
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
